memclr_reset_seq: RTL and testbench

//  Parametrised reset sequencer and memory-clear engine for the top-level wrapper.

---
 rtl/memclr_pkg.sv | 11 +
 rtl/memclr_sync.sv | 23 ++
 rtl/memclr_reset_seq.sv | 160 ++++++++++++++++
 tb/tb_memclr_reset_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memclr_pkg.sv
// rtl/memclr_pkg.sv - shared state type and counter sizing for the reset sequencer
package memclr_pkg;

  typedef enum logic [1:0] {HOLD, CLEAR, IDLE, SOFT} memclr_state_t;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memclr_sync.sv
// rtl/memclr_sync.sv - W-wide two-flop synchroniser for asynchronous hard-reset requests
module memclr_sync #(
  parameter int W = 4
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/memclr_reset_seq.sv
// rtl/memclr_reset_seq.sv - reset sequencer: stretched hard reset, RAM fill sweep, soft-reset pulses
// Optional MEMCLR_RANGE_EN adds clr_start/clr_end to restrict the sweep to an address window.
module memclr_reset_seq
  import memclr_pkg::*;
#(
  parameter int                ADDR_W   = 21,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] FILL     = '1,
  parameter int                NUM_SRC  = 4,
  parameter int                STRETCH  = 16,
  parameter int                SOFT_LEN = 8
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] hard_req,
  input  logic               soft_req,
  input  logic               mem_ready,
`ifdef MEMCLR_RANGE_EN
  input  logic [ADDR_W-1:0]  clr_start,
  input  logic [ADDR_W-1:0]  clr_end,
`endif
  output logic               hard_reset,
  output logic               soft_reset,
  output logic               clr_we,
  output logic [ADDR_W-1:0]  clr_addr,
  output logic [DATA_W-1:0]  clr_data,
  output logic               clr_busy,
  output logic               clr_done
);

  localparam int CNT_W = cnt_width((STRETCH > SOFT_LEN) ? STRETCH : SOFT_LEN);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST    = CNT_W'(SOFT_LEN - 1);

  logic [NUM_SRC-1:0] req_sync;
  logic               req_any;

  memclr_sync #(.W(NUM_SRC)) u_sync (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .d       (hard_req),
    .q       (req_sync)
  );

  assign req_any = |req_sync;

  memclr_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] first_addr, last_addr;

`ifdef MEMCLR_RANGE_EN
  logic [ADDR_W-1:0] last_q, last_d;
  assign first_addr = clr_start;
  assign last_addr  = last_q;
`else
  assign first_addr = '0;
  assign last_addr  = '1;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
`ifdef MEMCLR_RANGE_EN
      last_q  <= '1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
`ifdef MEMCLR_RANGE_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
`ifdef MEMCLR_RANGE_EN
    last_d  = last_q;
`endif
    case (state_q)
      HOLD: begin
        if (req_any) begin
          cnt_d = '0;
        end else if (cnt_q == STRETCH_LAST) begin
          state_d = CLEAR;
          cnt_d   = '0;
          addr_d  = first_addr;
`ifdef MEMCLR_RANGE_EN
          // An inverted window collapses to a single write at the start address.
          last_d  = (clr_end < clr_start) ? clr_start : clr_end;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CLEAR: begin
        if (req_any) begin
          state_d = HOLD;
          cnt_d   = '0;
          addr_d  = '0;
        end else if (mem_ready) begin
          if (addr_q == last_addr) begin
            state_d = IDLE;
            addr_d  = '0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      IDLE: begin
        if (req_any) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (soft_req) begin
          state_d = SOFT;
          cnt_d   = '0;
        end
      end
      SOFT: begin
        if (req_any) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (soft_req) begin
          cnt_d = '0;
        end else if (cnt_q == SOFT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        addr_d  = '0;
      end
    endcase
  end

  // req_any is a flop output, so gating with it aborts the write/pulse in the request cycle itself.
  assign hard_reset = (state_q == HOLD) || (state_q == CLEAR);
  assign clr_busy   = (state_q == CLEAR);
  assign clr_we     = (state_q == CLEAR) && !req_any;
  assign soft_reset = (state_q == SOFT) && !req_any;
  assign clr_addr   = addr_q;
  assign clr_data   = clr_we ? FILL : '0;
  assign clr_done   = done_q;

endmodule

// File: tb/tb_memclr_reset_seq.sv
// tb/tb_memclr_reset_seq.sv - self-checking bench for memclr_reset_seq (ADDR_W=4, STRETCH=4, SOFT_LEN=3)
module tb_memclr_reset_seq;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam logic [DATA_W-1:0] FILL = 8'h5A;
  localparam int NUM_SRC  = 4;
  localparam int STRETCH  = 4;
  localparam int SOFT_LEN = 3;
  localparam int DEPTH    = 1 << ADDR_W;

  logic               clk_sys = 1'b0;
  logic               reset_n = 1'b0;
  logic [NUM_SRC-1:0] hard_req = '0;
  logic               soft_req = 1'b0;
  logic               mem_ready = 1'b1;
  logic               hard_reset, soft_reset, clr_we, clr_busy, clr_done;
  logic [ADDR_W-1:0]  clr_addr;
  logic [DATA_W-1:0]  clr_data;
`ifdef MEMCLR_RANGE_EN
  logic [ADDR_W-1:0]  clr_start = '0;
  logic [ADDR_W-1:0]  clr_end = '1;
`endif

  int checks = 0;
  int errors = 0;

  memclr_reset_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FILL(FILL), .NUM_SRC(NUM_SRC),
    .STRETCH(STRETCH), .SOFT_LEN(SOFT_LEN)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .hard_req   (hard_req),
    .soft_req   (soft_req),
    .mem_ready  (mem_ready),
`ifdef MEMCLR_RANGE_EN
    .clr_start  (clr_start),
    .clr_end    (clr_end),
`endif
    .hard_reset (hard_reset),
    .soft_reset (soft_reset),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr),
    .clr_data   (clr_data),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done)
  );

  always #5 clk_sys = ~clk_sys;

  // Transaction log: every accepted write, every done pulse, busy cycle count.
  int cyc = 0;
  int busy_cnt = 0;
  int coincide = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  int wr_cyc[$];
  int done_cyc[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (clr_we && mem_ready) begin
      wr_addr.push_back(clr_addr);
      wr_data.push_back(clr_data);
      wr_cyc.push_back(cyc);
    end
    if (clr_done) done_cyc.push_back(cyc);
    if (clr_done && clr_we) coincide <= coincide + 1;
    if (clr_busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_hard(input int idx);
    hard_req[idx] = 1'b1;
    step();
    hard_req = '0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (clr_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Number of logged writes from index base that differ from FILL at first, first+1, ...
  function automatic int bad_writes(input int base, input int n, input int first);
    int bad;
    bad = 0;
    if (wr_addr.size() < base + n) return n;
    for (int i = 0; i < n; i++)
      if (wr_addr[base+i] !== ADDR_W'(first + i) || wr_data[base+i] !== FILL) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; hard_req = '0; soft_req = 1'b0; mem_ready = 1'b1;
    repeat (3) step();
    checks++; if (hard_reset !== 1'b1) begin errors++; $display("FAIL reset_hard_reset: got %b want 1", hard_reset); end
    checks++; if (soft_reset !== 1'b0) begin errors++; $display("FAIL reset_soft_reset: got %b want 0", soft_reset); end
    checks++; if (clr_we !== 1'b0) begin errors++; $display("FAIL reset_clr_we: got %b want 0", clr_we); end
    checks++; if (clr_addr !== '0) begin errors++; $display("FAIL reset_clr_addr: got %0d want 0", clr_addr); end
    checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", clr_busy, clr_done); end
  endtask

  task automatic test_power_on();
    int w0, d0, b0, rel, bad;
    bit ok;
    w0 = wr_addr.size(); d0 = done_cyc.size(); b0 = busy_cnt;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    rel = cyc;
    bad = 0;
    for (int i = 0; i < STRETCH; i++) begin
      if (clr_busy !== 1'b0 || hard_reset !== 1'b1) bad++;
      step();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pwr_hold_cycles: got %0d bad cycles want 0", bad); end
    checks++; if (clr_we !== 1'b1 || clr_addr !== '0) begin errors++; $display("FAIL pwr_clear_start: got we=%b addr=%0d want we=1 addr=0", clr_we, clr_addr); end
    wait_done(4 * DEPTH, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pwr_done_timeout: got no clr_done want one"); end
    checks++; if (hard_reset !== 1'b0 || clr_busy !== 1'b0 || clr_we !== 1'b0) begin errors++; $display("FAIL pwr_done_outputs: got hr=%b busy=%b we=%b want 000", hard_reset, clr_busy, clr_we); end
    step();
    checks++; if (clr_done !== 1'b0) begin errors++; $display("FAIL pwr_done_width: got %b want 0", clr_done); end
    checks++; if (wr_addr.size() - w0 !== DEPTH) begin errors++; $display("FAIL pwr_write_count: got %0d want %0d", wr_addr.size() - w0, DEPTH); end
    checks++; if (bad_writes(w0, DEPTH, 0) !== 0) begin errors++; $display("FAIL pwr_write_seq: got %0d bad want 0", bad_writes(w0, DEPTH, 0)); end
    if (wr_cyc.size() >= w0 + DEPTH && done_cyc.size() > d0) begin
      checks++; if (wr_cyc[w0] - rel !== STRETCH) begin errors++; $display("FAIL pwr_first_write_time: got %0d want %0d", wr_cyc[w0] - rel, STRETCH); end
      checks++; if (done_cyc[d0] - wr_cyc[w0+DEPTH-1] !== 1) begin errors++; $display("FAIL pwr_done_time: got %0d want 1", done_cyc[d0] - wr_cyc[w0+DEPTH-1]); end
    end
    checks++; if (busy_cnt - b0 !== DEPTH) begin errors++; $display("FAIL pwr_busy_cycles: got %0d want %0d", busy_cnt - b0, DEPTH); end
  endtask

  task automatic test_stall();
    int w0, b0, d0;
    bit ok, found;
    w0 = wr_addr.size(); b0 = busy_cnt; d0 = done_cyc.size();
    pulse_hard(1);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (clr_we && clr_addr == ADDR_W'(5)) begin found = 1'b1; break; end
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_reach_addr5: got timeout want addr 5"); end
    mem_ready = 1'b0;
    repeat (3) step();
    checks++; if (clr_addr !== ADDR_W'(5) || clr_we !== 1'b1) begin errors++; $display("FAIL stall_addr_held: got addr=%0d we=%b want 5 1", clr_addr, clr_we); end
    mem_ready = 1'b1;
    wait_done(4 * DEPTH, ok);
    step();
    checks++; if (!ok || done_cyc.size() - d0 !== 1) begin errors++; $display("FAIL stall_done: got %0d pulses want 1", done_cyc.size() - d0); end
    checks++; if (bad_writes(w0, DEPTH, 0) !== 0 || wr_addr.size() - w0 !== DEPTH) begin errors++; $display("FAIL stall_write_seq: got %0d writes want %0d", wr_addr.size() - w0, DEPTH); end
    checks++; if (busy_cnt - b0 !== DEPTH + 3) begin errors++; $display("FAIL stall_sweep_len: got %0d want %0d", busy_cnt - b0, DEPTH + 3); end
    if (wr_cyc.size() >= w0 + 6) begin
      checks++; if (wr_cyc[w0+5] - wr_cyc[w0+4] !== 4) begin errors++; $display("FAIL stall_gap: got %0d want 4", wr_cyc[w0+5] - wr_cyc[w0+4]); end
    end
  endtask

  task automatic test_random_stall();
    int w0, b0, d0, stalls;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      w0 = wr_addr.size(); b0 = busy_cnt; d0 = done_cyc.size();
      stalls = 0; ok = 1'b0;
      pulse_hard($urandom_range(0, NUM_SRC - 1));
      for (int i = 0; i < 300; i++) begin
        mem_ready = ($urandom_range(0, 2) != 0);
        if (clr_busy && !mem_ready) stalls++;
        step();
        if (clr_done) begin ok = 1'b1; break; end
      end
      mem_ready = 1'b1;
      step();
      checks++; if (!ok || done_cyc.size() - d0 !== 1) begin errors++; $display("FAIL rstall_done: got %0d pulses want 1", done_cyc.size() - d0); end
      checks++; if (wr_addr.size() - w0 !== DEPTH || bad_writes(w0, DEPTH, 0) !== 0) begin errors++; $display("FAIL rstall_write_seq: got %0d writes want %0d", wr_addr.size() - w0, DEPTH); end
      checks++; if (busy_cnt - b0 !== DEPTH + stalls) begin errors++; $display("FAIL rstall_sweep_len: got %0d want %0d", busy_cnt - b0, DEPTH + stalls); end
    end
  endtask

  task automatic test_abort();
    int w0, d0;
    bit ok, found;
    pulse_hard(3);
    w0 = wr_addr.size(); d0 = done_cyc.size();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (clr_we && clr_addr == ADDR_W'(7)) begin found = 1'b1; break; end
      step();
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_reach_addr7: got timeout want addr 7"); end
    hard_req[2] = 1'b1;
    step();
    hard_req = '0;
    step();
    checks++; if (clr_we !== 1'b0 || hard_reset !== 1'b1) begin errors++; $display("FAIL abort_same_cycle: got we=%b hr=%b want 0 1", clr_we, hard_reset); end
    step();
    checks++; if (clr_addr !== '0 || clr_busy !== 1'b0 || hard_reset !== 1'b1 || clr_done !== 1'b0) begin errors++; $display("FAIL abort_hold: got addr=%0d busy=%b hr=%b done=%b want 0 0 1 0", clr_addr, clr_busy, hard_reset, clr_done); end
    wait_done(4 * DEPTH, ok);
    step();
    checks++; if (!ok || done_cyc.size() - d0 !== 1) begin errors++; $display("FAIL abort_done_count: got %0d want 1", done_cyc.size() - d0); end
    checks++; if (wr_addr.size() - w0 !== 9 + DEPTH) begin errors++; $display("FAIL abort_write_count: got %0d want %0d", wr_addr.size() - w0, 9 + DEPTH); end
    checks++; if (bad_writes(w0, 9, 0) !== 0 || bad_writes(w0 + 9, DEPTH, 0) !== 0) begin errors++; $display("FAIL abort_write_seq: got %0d/%0d bad want 0/0", bad_writes(w0, 9, 0), bad_writes(w0 + 9, DEPTH, 0)); end
  endtask

  task automatic test_soft();
    bit req[30];
    bit exp_sr;
    int bad;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 30; i++) req[i] = 1'b0;
      if (p == 0) req[2] = 1'b1;
      else if (p == 1) begin req[2] = 1'b1; req[4] = 1'b1; end
      else for (int i = 0; i < 22; i++) req[i] = ($urandom_range(0, 3) == 0);
      bad = 0;
      for (int i = 0; i < 30; i++) begin
        exp_sr = 1'b0;
        for (int j = i - SOFT_LEN; j < i; j++) if (j >= 0 && req[j]) exp_sr = 1'b1;
        checks++;
        if (soft_reset !== exp_sr || hard_reset !== 1'b0) begin
          errors++;
          $display("FAIL soft_p%0d_c%0d: got sr=%b hr=%b want sr=%b hr=0", p, i, soft_reset, hard_reset, exp_sr);
        end
        soft_req = req[i];
        step();
      end
      soft_req = 1'b0;
    end
  endtask

  task automatic test_priority();
    int w0, d0, bad;
    bit ok;
    w0 = wr_addr.size(); d0 = done_cyc.size();
    hard_req[0] = 1'b1;
    step();
    step();
    soft_req = 1'b1;
    hard_req = '0;
    step();
    soft_req = 1'b0;
    checks++; if (soft_reset !== 1'b0 || hard_reset !== 1'b1) begin errors++; $display("FAIL prio_hard_wins: got sr=%b hr=%b want 0 1", soft_reset, hard_reset); end
    bad = 0; ok = 1'b0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      soft_req = clr_busy && (clr_addr == ADDR_W'(3) || clr_addr == ADDR_W'(DEPTH - 1));
      step();
      if (soft_reset !== 1'b0) bad++;
      if (clr_done) begin ok = 1'b1; break; end
    end
    soft_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (soft_reset !== 1'b0) bad++;
    end
    checks++; if (!ok || done_cyc.size() - d0 !== 1) begin errors++; $display("FAIL prio_done: got %0d pulses want 1", done_cyc.size() - d0); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL prio_soft_ignored: got %0d soft cycles want 0", bad); end
    checks++; if (wr_addr.size() - w0 !== DEPTH || bad_writes(w0, DEPTH, 0) !== 0) begin errors++; $display("FAIL prio_write_seq: got %0d writes want %0d", wr_addr.size() - w0, DEPTH); end
  endtask

`ifdef MEMCLR_RANGE_EN
  task automatic test_range();
    int w0;
    bit ok;
    w0 = wr_addr.size();
    clr_start = ADDR_W'(3); clr_end = ADDR_W'(6);
    pulse_hard(0);
    wait_done(4 * DEPTH, ok);
    step();
    checks++; if (!ok || wr_addr.size() - w0 !== 4 || bad_writes(w0, 4, 3) !== 0) begin errors++; $display("FAIL range_3_6: got %0d writes want 4 at 3..6", wr_addr.size() - w0); end
    w0 = wr_addr.size();
    clr_start = ADDR_W'(6); clr_end = ADDR_W'(3);
    pulse_hard(1);
    wait_done(4 * DEPTH, ok);
    step();
    checks++; if (!ok || wr_addr.size() - w0 !== 1 || bad_writes(w0, 1, 6) !== 0) begin errors++; $display("FAIL range_6_3: got %0d writes want 1 at 6", wr_addr.size() - w0); end
    clr_start = '0; clr_end = '1;
  endtask
`endif

  task automatic test_invariants();
    checks++; if (coincide !== 0) begin errors++; $display("FAIL done_with_we: got %0d cycles want 0", coincide); end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_stall();
    test_random_stall();
    test_abort();
    test_soft();
    test_priority();
`ifdef MEMCLR_RANGE_EN
    test_range();
`endif
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
